// File: rtl/tdm_lane_mux_pkg.sv
// rtl/tdm_lane_mux_pkg.sv - shared constants and helpers for the lane multiplexer
package tdm_lane_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel index width; never narrower than one bit so a 2-lane mux still has an index.
  function automatic int ch_w_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Lowest bit position of lane k inside the packed lane bus.
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/tdm_lane_mux_rr_pick.sv
// rtl/tdm_lane_mux_rr_pick.sv - combinational rotated priority finder
module rr_pick #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   base,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  logic [CH_W:0]   sum;
  logic [CH_W-1:0] cand;

  // Walk base, base+1, ... cyclically and report the first requesting lane.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, base} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) begin
        sum = sum - (CH_W+1)'(NUM_CH);
      end
      cand = sum[CH_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tdm_lane_mux.sv
// rtl/tdm_lane_mux.sv - N-lane time-division mux with handshake and skip-idle rotation
module tdm_lane_mux
  import tdm_lane_mux_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int W      = 8,
  parameter int CH_W   = ch_w_of(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                mode,
  input  logic [NUM_CH*W-1:0] in_data,
  input  logic [NUM_CH-1:0]   in_valid,
  output logic [NUM_CH-1:0]   in_ready,
  output logic [W-1:0]        out_data,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  input  logic                out_ready
);

  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] sel;
  logic [CH_W-1:0] rr_idx;
  logic            rr_found;
  logic            advance;
  logic [W-1:0]    lanes [NUM_CH];

  // Next pointer with an explicit wrap so non-power-of-2 lane counts stay in range.
  function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] x);
    return (x == CH_W'(NUM_CH-1)) ? '0 : x + CH_W'(1);
  endfunction

  rr_pick #(
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W)
  ) u_rr_pick (
    .req  (in_valid),
    .base (ptr),
    .found(rr_found),
    .idx  (rr_idx)
  );

  // Unpack the lane bus into an indexable array.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      lanes[k] = in_data[lane_lsb(k, W) +: W];
    end
  end

  assign advance = ~out_valid | out_ready;
  assign sel     = (mode == MODE_RR) ? rr_idx : ptr;

  // Acknowledge only the selected lane, and only when its beat is actually taken.
  always_comb begin
    in_ready = '0;
    if (reset && enable && advance && in_valid[sel]) begin
      in_ready[sel] = 1'b1;
    end
  end

  // Output stage and slot pointer; everything holds while downstream stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (advance) begin
      if (!enable) begin
        ptr       <= '0;
        out_valid <= 1'b0;
      end else if (mode == MODE_FIXED) begin
        out_data  <= lanes[sel];
        out_ch    <= sel;
        out_valid <= in_valid[sel];
        ptr       <= wrap_inc(ptr);
      end else if (rr_found) begin
        out_data  <= lanes[sel];
        out_ch    <= sel;
        out_valid <= 1'b1;
        ptr       <= wrap_inc(sel);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_lane_mux.sv
// tb/tb_tdm_lane_mux.sv - randomized and directed bench against a behavioural lane mux model
module tb_tdm_lane_mux;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            mode;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic [CW-1:0]   out_ch;
  logic            out_ready;

  always #5 clk = ~clk;

  tdm_lane_mux #(
    .NUM_CH(N),
    .W     (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ch   (out_ch),
    .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int           m_ptr;
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_ch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lane(input int k);
    return in_data[k*W +: W];
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
  endtask

  // One clock with the currently applied inputs: check the handshake mid-cycle,
  // advance the model, then check the registered outputs just after the edge.
  task automatic step();
    int          s;
    bit          hit;
    bit          adv;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    adv = !m_valid || out_ready;
    hit = 0;
    s   = m_ptr;
    if (mode == 1'b0) begin
      hit = in_valid[m_ptr];
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!hit && in_valid[(m_ptr + i) % N]) begin
          hit = 1;
          s   = (m_ptr + i) % N;
        end
      end
    end
    exp_rdy = '0;
    if (adv && enable && hit) exp_rdy[s] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (adv) begin
      if (!enable) begin
        m_ptr   = 0;
        m_valid = 1'b0;
      end else if (mode == 1'b0) begin
        m_data  = lane(s);
        m_ch    = s;
        m_valid = hit;
        m_ptr   = (m_ptr + 1) % N;
      end else if (hit) begin
        m_data  = lane(s);
        m_ch    = s;
        m_valid = 1'b1;
        m_ptr   = (s + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_ch", 32'(out_ch), 32'(m_ch));
  endtask

  logic [W-1:0] fix_seq [4];

  initial begin
    fix_seq[0] = 8'h11; fix_seq[1] = 8'h22; fix_seq[2] = 8'h33; fix_seq[3] = 8'h11;

    reset     = 1'b0;
    enable    = 1'b1;
    mode      = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    model_reset();

    // Reset held for three edges: everything parked at zero.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_ch", 32'(out_ch), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
    end
    reset = 1'b1;

    // Idle lanes for one full rotation brings the pointer back to lane 0.
    repeat (N) step();

    // Fixed rotation with all lanes valid.
    in_data  = {8'h33, 8'h22, 8'h11};
    in_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fix_seq", 32'(out_data), 32'(fix_seq[i]));
    end
    step();
    check("bp_pre", 32'(out_data), 32'h22);

    // Backpressure while 0x22 is held.
    out_ready = 1'b0;
    repeat (2) begin
      step();
      check("bp_hold", 32'(out_data), 32'h22);
    end
    out_ready = 1'b1;
    step();
    check("bp_release", 32'(out_data), 32'h33);

    // Park with the pointer at lane 2, then resume from lane 0.
    step();
    step();
    check("park_pre", 32'(out_ch), 32'd1);
    enable = 1'b0;
    step();
    check("park_valid", 32'(out_valid), 32'd0);
    enable = 1'b1;
    step();
    check("park_resume", 32'(out_ch), 32'd0);

    // Skip-idle rotation between lanes 0 and 2.
    mode     = 1'b1;
    in_valid = 3'b101;
    repeat (4) begin
      step();
      check("rr_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 3'b000;
    repeat (2) step();
    in_valid = 3'b010;
    step();
    check("rr_single", 32'(out_ch), 32'd1);

    // Asynchronous reset between edges.
    mode     = 1'b0;
    in_valid = 3'b111;
    step();
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    step();
    check("arst_resume_ch", 32'(out_ch), 32'd0);
    check("arst_resume_data", 32'(out_data), 32'h11);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      enable    = ($urandom_range(0, 9) != 0);
      mode      = $urandom_range(0, 1);
      in_valid  = N'($urandom);
      in_data   = (N*W)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_lane_mux.md
Name: tdm_lane_mux

Overview:
- Parametrised time-division multiplexer that merges NUM_CH input lanes of W bits onto one registered output lane.
- Generalises the 2:1 alternating clock-slot mux to N channels.
- Adds a per-lane valid/ready handshake, downstream backpressure and a skip-idle round-robin mode.
- Sits between parallel compressor/hash lanes and the single-width downstream stage of the kernel datapath.

Parameters:
- NUM_CH, 2, number of input lanes (>=2; non-power-of-2 values are legal).
- W, 8, data width per lane in bits.
- CH_W, $clog2(NUM_CH), width of the channel index. Derived; never overridden.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  slot rotation enable.
- mode  input  1  0 = fixed rotation, 1 = skip-idle round-robin.
- in_data  input  NUM_CH*W  packed lanes; lane k occupies bits [k*W +: W].
- in_valid  input  NUM_CH  per-lane data valid.
- in_ready  output  NUM_CH  per-lane accept; one-hot or zero; combinational.
- out_data  output  W  registered selected data.
- out_valid  output  1  registered valid.
- out_ch  output  CH_W  registered index of the lane that produced out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset, asynchronous, while reset=0: ptr=0, out_valid=0, out_data=0, out_ch=0. in_ready=0 combinationally. Reset mid-transfer drops the held beat; no lane is acknowledged for it.
- advance = ~out_valid | out_ready. When advance=0, all output registers and ptr hold, and in_ready=0.
- enable=0 with advance=1: ptr<=0, out_valid<=0, in_ready=0. out_data and out_ch hold. This mirrors the legacy "park on lane A" behaviour.
- Fixed mode (mode=0), enable=1, advance=1:
  - sel=ptr.
  - out_data<=lane[sel], out_ch<=sel, out_valid<=in_valid[sel].
  - ptr<=(ptr==NUM_CH-1)?0:ptr+1. The pointer advances even when the slot is empty, so timing is deterministic.
- Round-robin mode (mode=1), enable=1, advance=1:
  - sel = first k in cyclic order ptr, ptr+1, ..., ptr-1 with in_valid[k]=1.
  - If a lane is found: out_data<=lane[sel], out_ch<=sel, out_valid<=1, ptr<=sel+1 with wrap at NUM_CH.
  - If no lane is valid: out_valid<=0 and ptr holds.
- in_ready[sel]=1 iff enable & advance & in_valid[sel] & reset. All other bits are 0. A lane beat is consumed exactly on the cycle its in_ready is high.
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 beat/cycle with no bubbles when out_ready=1.
- Mode switch: sampled every cycle; ptr carries over unchanged.
- Wrap arithmetic: compare against NUM_CH-1 explicitly. Never rely on natural CH_W overflow.
- Simultaneous events:
  - out_ready=0 together with an enable fall: hold takes priority; the enable effect applies on the first cycle with advance=1.
  - A lane valid that drops without ready is permitted. It is simply not taken.

Decomposition:
- Shared package (kernel common):
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
  - clog2-based CH_W helper with a minimum of 1.
  - Lane slice helper function.
- One sub-module: rr_pick. Combinational rotated priority finder.
  - Inputs: req[NUM_CH], base[CH_W].
  - Outputs: found, idx[CH_W].
  - Fixed mode bypasses it and uses idx=ptr.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release with all lane valids low, enable=1, mode=0 -> out_valid=0, out_data=0, out_ch=0 throughout; ptr cycles 0,1,2,0 with NUM_CH=3.
- Fixed rotation: NUM_CH=3, W=8, lanes=0x11/0x22/0x33 all valid, out_ready=1 -> out_data 0x11,0x22,0x33,0x11 on consecutive cycles with out_ch 0,1,2,0; in_ready one-hot rotating 001,010,100.
- Round-robin skip: NUM_CH=4, only lanes 1 and 3 valid, mode=1 -> out_ch alternates 1,3,1,3 with out_valid=1 every cycle; with all lanes invalid, out_valid=0 and ptr holds.
- Backpressure: steady fixed-mode stream, drop out_ready for 2 cycles while out_data=0x22 -> out_data stays 0x22, in_ready=0; on release the next beat is 0x33 with no loss or duplication.
- Enable park: deassert enable while ptr=2 -> next cycle out_valid=0; on re-enable the first beat is from lane 0.
- Async reset mid-stream: assert reset between clock edges -> out_valid=0 and in_ready=0 immediately without waiting for an edge; after release, output resumes from lane 0.
